// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester and peripheral bus bundle for bus_arbiter
interface bus_arbiter_if #(
    parameter int N  = 2,
    parameter int AW = 14,
    parameter int DW = 8
);
    logic [N-1:0]    req_stb;
    logic [N-1:0]    req_wr;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_a;
    logic [N*DW-1:0] req_d;
    logic [N-1:0]    req_ack;
    logic [DW-1:0]   rdata;
    logic [N-1:0]    grant;
    logic [AW-1:0]   adr;
    logic            we;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;

    // Arbiter view: consumes requests and slave read data, drives the shared bus.
    modport slave (
        input  req_stb, req_wr, req_lock, req_a, req_d, dat_r,
        output req_ack, rdata, grant, adr, we, dat_w
    );

    // Environment view: requesters plus the peripheral read-data return.
    modport master (
        output req_stb, req_wr, req_lock, req_a, req_d, dat_r,
        input  req_ack, rdata, grant, adr, we, dat_w
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter onto a shared peripheral bus
module bus_arbiter #(
    parameter int            N        = 2,
    parameter int            AW       = 14,
    parameter int            DW       = 8,
    parameter logic [AW-1:0] IDLE_ADR = 14'h3FFF
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] win_q, win_d;
    logic [IW-1:0] last_q, last_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          we_q, we_d;
    logic [DW-1:0] dat_w_q, dat_w_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [IW-1:0] pick;
    logic          found;
    int            rr_idx;
    logic [IW-1:0] lat_idx;
    logic [AW-1:0] lat_a;
    logic [DW-1:0] lat_d;
    logic          lat_wr;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Round-robin search starting one past the previous owner.
    always_comb begin
        pick   = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int k = 1; k <= N; k++) begin
            rr_idx = int'(last_q) + k;
            if (rr_idx >= N) rr_idx = rr_idx - N;
            if (!found && bus.req_stb[rr_idx]) begin
                found = 1'b1;
                pick  = IW'(rr_idx);
            end
        end
    end

    // Fields to latch: the new winner from IDLE, the current owner on a locked re-issue.
    always_comb begin
        lat_idx = (state_q == IDLE) ? pick : win_q;
        lat_a   = bus.req_a[lat_idx*AW +: AW];
        lat_d   = bus.req_d[lat_idx*DW +: DW];
        lat_wr  = bus.req_wr[lat_idx];
    end

    // Next-state and next-output computation for the IDLE/ISSUE/CAPTURE sequence.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        adr_d   = adr_q;
        we_d    = we_q;
        dat_w_d = dat_w_q;
        grant_d = grant_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    win_d   = pick;
                    grant_d = onehot(pick);
                    adr_d   = lat_a;
                    we_d    = lat_wr;
                    dat_w_d = lat_d;
                end
            end
            ISSUE: begin
                // Slave data is valid at the end of the address cycle.
                state_d = CAPTURE;
                we_d    = 1'b0;
                rdata_d = bus.dat_r;
                ack_d   = onehot(win_q);
            end
            CAPTURE: begin
                if (bus.req_lock[win_q] && bus.req_stb[win_q]) begin
                    state_d = ISSUE;
                    adr_d   = lat_a;
                    we_d    = lat_wr;
                    dat_w_d = lat_d;
                end else begin
                    state_d = IDLE;
                    last_d  = win_q;
                    grant_d = '0;
                    adr_d   = IDLE_ADR;
                    we_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                adr_d   = IDLE_ADR;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and registered bus outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            last_q  <= IW'(N - 1);
            adr_q   <= IDLE_ADR;
            we_q    <= 1'b0;
            dat_w_q <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            dat_w_q <= dat_w_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.adr     = adr_q;
    assign bus.we      = we_q;
    assign bus.dat_w   = dat_w_q;
    assign bus.grant   = grant_q;
    assign bus.req_ack = ack_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter N, default 2: number of requesters, 2..4.
REQ-002 SHALL have parameter AW, default 14: peripheral bus address width.
REQ-003 SHALL have parameter DW, default 8: peripheral bus data width.
REQ-004 SHALL have parameter IDLE_ADR, default 14'h3FFF: address driven when the bus is idle; decoded by no slave.
REQ-005 clk  input  1  single clock, all logic rising-edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_stb  input  N  per-requester transaction request.
REQ-008 req_wr  input  N  per-requester write (1) or read (0).
REQ-009 req_lock  input  N  per-requester hold-grant for back-to-back transactions.
REQ-010 req_a  input  N*AW  flattened addresses, requester i at bits [i*AW +: AW].
REQ-011 req_d  input  N*DW  flattened write data, requester i at bits [i*DW +: DW].
REQ-012 req_ack  output  N  one-cycle completion pulse per requester.
REQ-013 rdata  output  DW  read data for the acked transaction, valid while req_ack is high.
REQ-014 grant  output  N  one-hot current owner; all zero when idle.
REQ-015 adr  output  AW  shared bus address to slaves.
REQ-016 we  output  1  shared bus write enable.
REQ-017 dat_w  output  DW  shared bus write data.
REQ-018 dat_r  input  DW  OR-combined slave read data, valid one cycle after adr is presented.

Function
REQ-019 SHALL implement states IDLE, ISSUE and CAPTURE.
REQ-020 IDLE: adr=IDLE_ADR, we=0, grant=0; if any req_stb is high, SHALL select a winner, latch its wr/a/d and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-021 Winner selection SHALL be round-robin: search starts at index (last+1) mod N, where last is the previously granted index (reset value N-1, so requester 0 wins first).
REQ-022 ISSUE: SHALL drive adr=latched address, we=latched wr, dat_w=latched data and grant=one-hot winner for exactly one cycle, then go to CAPTURE.
REQ-023 CAPTURE: SHALL hold adr, force we=0, register dat_r into rdata and pulse req_ack[winner] for one cycle.
REQ-024 From CAPTURE, if req_lock[winner] and req_stb[winner] are both high, SHALL re-latch that requester's fields and return to ISSUE with grant unchanged; otherwise SHALL go to IDLE, release grant and update last.
REQ-025 Latency from req_stb sampled high in IDLE to req_ack: 2 cycles; unlocked throughput 1 transaction per 3 cycles, locked 1 per 2.
REQ-026 Requesters SHALL hold req_stb, req_wr, req_a and req_d stable until req_ack; a req_stb still high in the cycle after req_ack is a new request.
REQ-027 Changes on a non-winning requester's inputs during ISSUE/CAPTURE SHALL not affect the bus.
REQ-028 A requester deasserting req_stb before ack is a protocol violation; the latched transaction SHALL still complete and be acked.
REQ-029 For a write, rdata SHALL carry whatever dat_r returns and is don't-care to the requester.
REQ-030 At most one req_ack bit SHALL be high in any cycle; we SHALL be high only in ISSUE.

Reset
REQ-031 On rst high, asynchronously: state=IDLE, adr=IDLE_ADR, we=0, dat_w=0, grant=0, req_ack=0, rdata=0, last=N-1.
REQ-032 Reset mid-transaction SHALL abort it with no ack; requesters retry after rst falls.
REQ-033 The first IDLE evaluation SHALL occur on the first clk edge after rst deasserts.

Verification
REQ-034 Single read: req_stb[0]=1, wr=0, a=14'h0010, slave returns 8'h5A -> ISSUE adr=0010, we=0; ack[0] 2 cycles later with rdata=5A.
REQ-035 Single write: req 1 writes 8'hC3 to 14'h0000 -> one cycle with we=1, adr=0000, dat_w=C3, grant=2'b10; ack[1]; we=0 in CAPTURE.
REQ-036 Contention: both requesters continuously request -> grants alternate 0,1,0,1; neither starves; one ack per 3 cycles.
REQ-037 Lock: req_lock[1]=1 for 3 queued writes while req 0 waits -> three back-to-back ISSUE/CAPTURE pairs to req 1 (2-cycle spacing), then req 0 is granted.
REQ-038 Reset mid-op: assert rst during CAPTURE -> req_ack stays 0, adr=3FFF, grant=0 immediately; after release, a pending req 1 completes normally.
REQ-039 Idle: no requests for 100 cycles -> adr=3FFF, we=0, grant=0 throughout.
